// File: rtl/tx_burst_ramper_pkg.sv
// Shared TX inband constants: burst ramp state encoding and I/Q sample width.
package tx_burst_ramper_pkg;

   localparam int SAMPLE_W = 16;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      RAMP_UP   = 2'd1,
      ACTIVE    = 2'd2,
      RAMP_DOWN = 2'd3
   } ramp_state_e;

endpackage

// File: rtl/tx_burst_ramper_iq_scale.sv
// tx_iq_scale: signed I/Q times unsigned gain, arithmetic right shift by RAMP_LOG2
// (floor rounding); full-scale gain returns the input unchanged.
module tx_iq_scale
   import tx_burst_ramper_pkg::*;
#(
   parameter int RAMP_LOG2 = 4
) (
   input  logic [SAMPLE_W-1:0]  in_i,
   input  logic [SAMPLE_W-1:0]  in_q,
   input  logic [RAMP_LOG2:0]   gain,
   output logic [SAMPLE_W-1:0]  out_i,
   output logic [SAMPLE_W-1:0]  out_q
);

   localparam int PW = SAMPLE_W + 1 + RAMP_LOG2;

   logic signed [PW-1:0] gain_x;
   logic signed [PW-1:0] prod_i;
   logic signed [PW-1:0] prod_q;

   // Gain is unsigned: zero-extend it so the signed multiply never sees a negative factor.
   assign gain_x = $signed({{(PW-RAMP_LOG2-1){1'b0}}, gain});
   assign prod_i = $signed({{(PW-SAMPLE_W){in_i[SAMPLE_W-1]}}, in_i}) * gain_x;
   assign prod_q = $signed({{(PW-SAMPLE_W){in_q[SAMPLE_W-1]}}, in_q}) * gain_x;

   assign out_i = SAMPLE_W'(prod_i >>> RAMP_LOG2);
   assign out_q = SAMPLE_W'(prod_q >>> RAMP_LOG2);

endmodule

// File: rtl/tx_burst_ramper.sv
// TX burst ramper: linear gain ramp on burst start/end, advancing once per txstrobe.
// Define TX_BURST_RAMPER_BURSTCNT_EN to add the 16-bit burst_count output.
module tx_burst_ramper
   import tx_burst_ramper_pkg::*;
#(
   parameter int RAMP_LOG2 = 4
) (
   input  logic                 txclk,
   input  logic                 reset,
   input  logic                 txstrobe,
   input  logic                 ramp_en,
   input  logic                 tx_empty_in,
   input  logic [SAMPLE_W-1:0]  tx_i_in,
   input  logic [SAMPLE_W-1:0]  tx_q_in,
   output logic [SAMPLE_W-1:0]  tx_i_out,
   output logic [SAMPLE_W-1:0]  tx_q_out,
   output logic                 tx_active,
`ifdef TX_BURST_RAMPER_BURSTCNT_EN
   output logic [15:0]          burst_count,
`endif
   output logic [RAMP_LOG2:0]   gain
);

   localparam logic [RAMP_LOG2:0] GAIN_FULL = {1'b1, {RAMP_LOG2{1'b0}}};
   localparam logic [RAMP_LOG2:0] GAIN_ONE  = {{RAMP_LOG2{1'b0}}, 1'b1};

   ramp_state_e          state_q, state_d;
   logic [RAMP_LOG2:0]   gain_q, gain_d, gain_inc, gain_dec;
   logic [SAMPLE_W-1:0]  hold_i_q, hold_i_d, hold_q_q, hold_q_d;
   logic [SAMPLE_W-1:0]  out_i_q, out_i_d, out_q_q, out_q_d;
   logic [SAMPLE_W-1:0]  mul_i, mul_q, scaled_i, scaled_q;

   assign gain_inc = (gain_q == GAIN_FULL) ? GAIN_FULL : gain_q + 1'b1;
   assign gain_dec = (gain_q == '0) ? '0 : gain_q - 1'b1;

   always_comb begin
      state_d = state_q;
      gain_d  = gain_q;
      if (txstrobe) begin
         if (!ramp_en) begin
            state_d = IDLE;
            gain_d  = '0;
         end else begin
            unique case (state_q)
               IDLE: if (!tx_empty_in) begin
                  state_d = RAMP_UP;
                  gain_d  = GAIN_ONE;
               end
               // Direction reversals continue from the current gain, never jump.
               RAMP_UP, RAMP_DOWN: if (!tx_empty_in) begin
                  gain_d  = gain_inc;
                  state_d = (gain_inc == GAIN_FULL) ? ACTIVE : RAMP_UP;
               end else begin
                  gain_d  = gain_dec;
                  state_d = (gain_dec == '0) ? IDLE : RAMP_DOWN;
               end
               ACTIVE: if (tx_empty_in) begin
                  gain_d  = gain_dec;
                  state_d = RAMP_DOWN;
               end
               default: state_d = IDLE;
            endcase
         end
      end
   end

   // The buffer zero-masks data once empty, so the tail ramps the last real sample.
   assign mul_i = tx_empty_in ? hold_i_q : tx_i_in;
   assign mul_q = tx_empty_in ? hold_q_q : tx_q_in;

   tx_iq_scale #(.RAMP_LOG2(RAMP_LOG2)) u_scale (
      .in_i  (mul_i),
      .in_q  (mul_q),
      .gain  (gain_d),
      .out_i (scaled_i),
      .out_q (scaled_q)
   );

   always_comb begin
      hold_i_d = hold_i_q;
      hold_q_d = hold_q_q;
      out_i_d  = out_i_q;
      out_q_d  = out_q_q;
      if (txstrobe) begin
         if (!tx_empty_in) begin
            hold_i_d = tx_i_in;
            hold_q_d = tx_q_in;
         end
         if (!ramp_en) begin
            out_i_d = tx_empty_in ? '0 : tx_i_in;
            out_q_d = tx_empty_in ? '0 : tx_q_in;
         end else begin
            out_i_d = scaled_i;
            out_q_d = scaled_q;
         end
      end
   end

   always_ff @(posedge txclk) begin
      if (reset) begin
         state_q  <= IDLE;
         gain_q   <= '0;
         hold_i_q <= '0;
         hold_q_q <= '0;
         out_i_q  <= '0;
         out_q_q  <= '0;
      end else begin
         state_q  <= state_d;
         gain_q   <= gain_d;
         hold_i_q <= hold_i_d;
         hold_q_q <= hold_q_d;
         out_i_q  <= out_i_d;
         out_q_q  <= out_q_d;
      end
   end

   assign tx_i_out  = out_i_q;
   assign tx_q_out  = out_q_q;
   assign tx_active = (state_q != IDLE);
   assign gain      = gain_q;

`ifdef TX_BURST_RAMPER_BURSTCNT_EN
   logic [15:0] burst_count_q, burst_count_d;

   always_comb begin
      burst_count_d = burst_count_q;
      if (state_q == IDLE && state_d == RAMP_UP)
         burst_count_d = burst_count_q + 16'd1;
   end

   always_ff @(posedge txclk) begin
      if (reset) burst_count_q <= '0;
      else       burst_count_q <= burst_count_d;
   end

   assign burst_count = burst_count_q;
`endif

endmodule

// File: tb/tb_tx_burst_ramper.sv
// Directed bench for tx_burst_ramper (RAMP_LOG2=4): vector table plus ramp,
// reversal, reset and strobe-gap sequences; burst_count checks when the macro is set.
module tb_tx_burst_ramper;

   localparam int RL = 4;

   logic        txclk = 1'b0;
   logic        reset, txstrobe, ramp_en, tx_empty_in;
   logic [15:0] tx_i_in, tx_q_in, tx_i_out, tx_q_out;
   logic        tx_active;
   logic [RL:0] gain;
`ifdef TX_BURST_RAMPER_BURSTCNT_EN
   logic [15:0] burst_count;
`endif

   int n_chk  = 0;
   int n_fail = 0;

   tx_burst_ramper #(.RAMP_LOG2(RL)) dut (
      .txclk       (txclk),
      .reset       (reset),
      .txstrobe    (txstrobe),
      .ramp_en     (ramp_en),
      .tx_empty_in (tx_empty_in),
      .tx_i_in     (tx_i_in),
      .tx_q_in     (tx_q_in),
      .tx_i_out    (tx_i_out),
      .tx_q_out    (tx_q_out),
      .tx_active   (tx_active),
`ifdef TX_BURST_RAMPER_BURSTCNT_EN
      .burst_count (burst_count),
`endif
      .gain        (gain)
   );

   always #5 txclk = ~txclk;

   typedef struct {
      logic        stb, en, emp;
      logic [15:0] i, q, ei, eq;
      logic [RL:0] eg;
      logic        ea;
   } vec_t;

   vec_t tv[12];

   // Drive inputs, then sample 1 time unit after the next rising edge.
   task automatic drive(input logic stb, input logic en, input logic emp,
                        input logic [15:0] i, input logic [15:0] q);
      txstrobe = stb; ramp_en = en; tx_empty_in = emp; tx_i_in = i; tx_q_in = q;
      @(posedge txclk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_all(input string name, input logic [15:0] ei, input logic [15:0] eq,
                          input logic [RL:0] eg, input logic ea);
      chk({name, " i"}, 32'(tx_i_out), 32'(ei));
      chk({name, " q"}, 32'(tx_q_out), 32'(eq));
      chk({name, " gain"}, 32'(gain), 32'(eg));
      chk({name, " active"}, 32'(tx_active), 32'(ea));
   endtask

   task automatic do_reset();
      reset = 1'b1;
      drive(1'b1, 1'b1, 1'b0, 16'h5555, 16'h5555);
      drive(1'b1, 1'b1, 1'b0, 16'h5555, 16'h5555);
      reset = 1'b0;
   endtask

   initial begin
      //         stb   en    emp   i         q         exp_i     exp_q     gain   act
      tv[0]  = '{1'b0, 1'b1, 1'b0, 16'h8000, 16'hFFFF, 16'h0000, 16'h0000, 5'd0, 1'b0};
      tv[1]  = '{1'b1, 1'b1, 1'b0, 16'h8000, 16'hFFFF, 16'hF800, 16'hFFFF, 5'd1, 1'b1};
      tv[2]  = '{1'b0, 1'b1, 1'b0, 16'h1234, 16'h1234, 16'hF800, 16'hFFFF, 5'd1, 1'b1};
      tv[3]  = '{1'b1, 1'b1, 1'b0, 16'h1000, 16'hF000, 16'h0200, 16'hFE00, 5'd2, 1'b1};
      tv[4]  = '{1'b1, 1'b1, 1'b1, 16'h0000, 16'h0000, 16'h0100, 16'hFF00, 5'd1, 1'b1};
      tv[5]  = '{1'b1, 1'b1, 1'b1, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 5'd0, 1'b0};
      tv[6]  = '{1'b1, 1'b0, 1'b0, 16'h7FFF, 16'h8001, 16'h7FFF, 16'h8001, 5'd0, 1'b0};
      tv[7]  = '{1'b0, 1'b0, 1'b0, 16'h1111, 16'h1111, 16'h7FFF, 16'h8001, 5'd0, 1'b0};
      tv[8]  = '{1'b1, 1'b0, 1'b1, 16'h2222, 16'h2222, 16'h0000, 16'h0000, 5'd0, 1'b0};
      tv[9]  = '{1'b1, 1'b1, 1'b0, 16'h0010, 16'h0001, 16'h0001, 16'h0000, 5'd1, 1'b1};
      tv[10] = '{1'b1, 1'b0, 1'b0, 16'h0ABC, 16'h0DEF, 16'h0ABC, 16'h0DEF, 5'd0, 1'b0};
      tv[11] = '{1'b1, 1'b1, 1'b1, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 5'd0, 1'b0};

      reset = 1'b0; txstrobe = 1'b0; ramp_en = 1'b1; tx_empty_in = 1'b1;
      tx_i_in = '0; tx_q_in = '0;

      do_reset();
      chk_all("reset", 16'h0000, 16'h0000, 5'd0, 1'b0);
`ifdef TX_BURST_RAMPER_BURSTCNT_EN
      chk("reset burst_count", 32'(burst_count), 32'd0);
`endif

      for (int n = 0; n < 12; n++) begin
         drive(tv[n].stb, tv[n].en, tv[n].emp, tv[n].i, tv[n].q);
         chk_all($sformatf("vec%0d", n), tv[n].ei, tv[n].eq, tv[n].eg, tv[n].ea);
      end

      // Full ramp up from 0x4000 / 0xC000, then ACTIVE.
      do_reset();
      drive(1'b1, 1'b1, 1'b1, 16'h4000, 16'hC000);
      chk_all("idle empty", 16'h0000, 16'h0000, 5'd0, 1'b0);
      for (int k = 1; k <= 16; k++) begin
         drive(1'b1, 1'b1, 1'b0, 16'h4000, 16'hC000);
         chk_all($sformatf("up%0d", k), 16'(k * 1024), 16'(-(k * 1024)), 5'(k), 1'b1);
      end
      drive(1'b1, 1'b1, 1'b0, 16'h4000, 16'hC000);
      chk_all("active hold", 16'h4000, 16'hC000, 5'd16, 1'b1);

      // Ramp down from held sample with zeroed inputs.
      for (int k = 15; k >= 0; k--) begin
         drive(1'b1, 1'b1, 1'b1, 16'h0000, 16'h0000);
         chk_all($sformatf("down%0d", k), 16'(k * 1024), 16'(-(k * 1024)), 5'(k), k != 0);
      end
      drive(1'b1, 1'b1, 1'b1, 16'h0000, 16'h0000);
      chk_all("idle after down", 16'h0000, 16'h0000, 5'd0, 1'b0);

      // Strobe every third cycle: gain only moves on strobe cycles.
      do_reset();
      for (int s = 1; s <= 3; s++) begin
         drive(1'b1, 1'b1, 1'b0, 16'h1000, 16'h1000);
         chk($sformatf("gap stb%0d gain", s), 32'(gain), 32'(s));
         for (int g = 0; g < 2; g++) begin
            drive(1'b0, 1'b1, 1'b0, 16'h7000, 16'h7000);
            chk($sformatf("gap hold%0d.%0d gain", s, g), 32'(gain), 32'(s));
            chk($sformatf("gap hold%0d.%0d i", s, g), 32'(tx_i_out), 32'(s * 16'h0100));
         end
      end

      // Reversal: continue to gain 5, empty for two strobes, then refill.
      drive(1'b1, 1'b1, 1'b0, 16'h1000, 16'h1000);
      drive(1'b1, 1'b1, 1'b0, 16'h1000, 16'h1000);
      chk_all("rev g5", 16'h0500, 16'h0500, 5'd5, 1'b1);
      drive(1'b1, 1'b1, 1'b1, 16'h0000, 16'h0000);
      chk_all("rev g4 down", 16'h0400, 16'h0400, 5'd4, 1'b1);
      drive(1'b1, 1'b1, 1'b1, 16'h0000, 16'h0000);
      chk_all("rev g3 down", 16'h0300, 16'h0300, 5'd3, 1'b1);
      drive(1'b1, 1'b1, 1'b0, 16'h1000, 16'h1000);
      chk_all("rev g4 up", 16'h0400, 16'h0400, 5'd4, 1'b1);
      drive(1'b1, 1'b1, 1'b0, 16'h1000, 16'h1000);
      chk_all("rev g5 up", 16'h0500, 16'h0500, 5'd5, 1'b1);

      // Reset mid-ramp at gain 9 overrides a strobe.
      for (int k = 6; k <= 9; k++) drive(1'b1, 1'b1, 1'b0, 16'h1000, 16'h1000);
      chk_all("pre-reset g9", 16'h0900, 16'h0900, 5'd9, 1'b1);
      reset = 1'b1;
      drive(1'b1, 1'b1, 1'b0, 16'h1000, 16'h1000);
      reset = 1'b0;
      chk_all("mid-ramp reset", 16'h0000, 16'h0000, 5'd0, 1'b0);

`ifdef TX_BURST_RAMPER_BURSTCNT_EN
      for (int b = 0; b < 3; b++) begin
         drive(1'b1, 1'b1, 1'b0, 16'h1000, 16'h1000);
         drive(1'b1, 1'b1, 1'b1, 16'h0000, 16'h0000);
      end
      chk("three bursts count", 32'(burst_count), 32'd3);
      chk("three bursts idle", 32'(tx_active), 32'd0);
      drive(1'b1, 1'b0, 1'b0, 16'h1357, 16'h2468);
      chk_all("bypass after bursts", 16'h1357, 16'h2468, 5'd0, 1'b0);
      chk("bypass no burst", 32'(burst_count), 32'd3);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/tx_burst_ramper.md
TX_BURST_RAMPER -- requirements
Module: tx_burst_ramper

Interface
REQ-001 Parameter RAMP_LOG2, default 4, log2 of ramp length in txstrobe ticks (legal 1..8).
REQ-002 txclk  input  1  clock; all logic on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 txstrobe  input  1  sample-advance qualifier, one txclk pulse per output sample.
REQ-005 ramp_en  input  1  1 = ramping active; 0 = bypass.
REQ-006 tx_empty_in  input  1  channel empty flag from the TX buffer (1 = no burst data).
REQ-007 tx_i_in, tx_q_in  input  16 each  signed two's-complement I/Q from the TX buffer.
REQ-008 tx_i_out, tx_q_out  output  16 each  signed ramped I/Q to the TX chain.
REQ-009 tx_active  output  1  high whenever the state is not IDLE.
REQ-010 gain  output  RAMP_LOG2+1  current ramp gain, 0..2^RAMP_LOG2.

Function
REQ-011 The block SHALL implement states IDLE, RAMP_UP, ACTIVE, RAMP_DOWN; state, gain and outputs change only on cycles with txstrobe=1.
REQ-012 IDLE: gain=0, outputs 0; on strobe with tx_empty_in=0 go to RAMP_UP, gain<=1.
REQ-013 RAMP_UP: on strobe with tx_empty_in=0, gain+1; on reaching 2^RAMP_LOG2 go to ACTIVE.
REQ-014 ACTIVE: gain held at 2^RAMP_LOG2; on strobe with tx_empty_in=1 go to RAMP_DOWN, gain-1.
REQ-015 RAMP_DOWN: on strobe with tx_empty_in=1, gain-1; on reaching 0 go to IDLE.
REQ-016 RAMP_UP seeing tx_empty_in=1 SHALL go to RAMP_DOWN, decrementing from current gain (no jump).
REQ-017 RAMP_DOWN seeing tx_empty_in=0 SHALL go to RAMP_UP, incrementing from current gain.
REQ-018 A sample-hold register SHALL capture tx_i_in/tx_q_in on every strobe with tx_empty_in=0; during RAMP_DOWN the held sample is the multiplicand (buffer zero-masks data when empty).
REQ-019 Output = (sample * gain) arithmetic-shifted right by RAMP_LOG2; signed 17+RAMP_LOG2-bit product; truncation toward minus infinity; gain=2^RAMP_LOG2 yields output equal to input exactly.
REQ-020 Output latency: one txclk after the strobe cycle; outputs hold between strobes.
REQ-021 ramp_en=0: outputs = tx_empty_in ? 0 : inputs (registered, same latency); state forced IDLE, gain=0.
REQ-022 ramp_en change mid-burst takes effect on the next strobe; 1->0 abandons the ramp without ramp-down.
REQ-023 No gain wrap: gain saturates at 0 and 2^RAMP_LOG2.

Reset
REQ-024 reset SHALL force IDLE, gain=0, hold register=0, tx_i_out=tx_q_out=0, tx_active=0, burst_count=0, mid-ramp included, reset overriding txstrobe.

Configuration
REQ-025 Macro TX_BURST_RAMPER_BURSTCNT_EN defined: extra output burst_count (16 bits) increments on each IDLE->RAMP_UP transition, wraps 0xFFFF->0.
REQ-026 Macro undefined: burst_count port and counter absent; all other behaviour identical.

Structure
REQ-027 State encoding constants (IDLE=0, RAMP_UP=1, ACTIVE=2, RAMP_DOWN=3) SHALL live in a shared TX inband package with the sample width constant (16).
REQ-028 One sub-module tx_iq_scale (signed I/Q by unsigned gain multiply-and-shift) SHALL be instantiated; FSM stays in the top.

Verification (RAMP_LOG2=4)
REQ-029 Constant input 0x4000, tx_empty_in 1->0 with strobe every cycle -> outputs 0x0400,0x0800,...,0x4000 on 16 consecutive strobes, then ACTIVE.
REQ-030 ACTIVE at 0x4000, tx_empty_in->1 with zeroed inputs -> outputs 0x3C00 down to 0x0000 from held sample, IDLE after 16 strobes, tx_active falls.
REQ-031 Input 0x8000 at gain 1 -> output 0xF800; input 0xFFFF at gain 1 -> 0xFFFF (floor).
REQ-032 Empty toggles 1 at gain 5 in RAMP_UP -> next gains 4,3; toggles 0 at gain 3 -> 4,5 (no discontinuity).
REQ-033 Reset asserted at gain 9 in RAMP_UP -> next cycle outputs 0, gain 0, IDLE; strobe gaps of 3 cycles -> gain changes only on strobe cycles.
REQ-034 With TX_BURST_RAMPER_BURSTCNT_EN, three bursts -> burst_count=3; ramp_en=0 -> input passes unchanged one cycle after strobe.
